tcu_operand_loader: RTL and testbench



---
 rtl/tcu_operand_loader_pkg.sv | 17 +
 rtl/tcu_operand_loader_if.sv | 14 +
 rtl/tcu_hold_timer.sv | 21 ++
 rtl/tcu_operand_loader.sv | 97 +++++++++
 tb/tb_tcu_operand_loader.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/tcu_operand_loader_pkg.sv
// Shared TCU definitions: word/row widths, loader state encoding and
// A/B/C segment offsets within the 48-word operand stream.
package tcu_operand_loader_pkg;
  localparam int DW        = 32;
  localparam int ROW_W     = 4 * DW;
  localparam int NUM_WORDS = 48;

  localparam int A_BASE = 0;
  localparam int B_BASE = 16;
  localparam int C_BASE = 32;

  typedef enum logic [1:0] {
    LOAD,
    HOLD,
    RESULT
  } state_e;
endpackage

// File: rtl/tcu_operand_loader_if.sv
// Operand word stream and result handshake between a producer/collector
// (master) and the operand loader (slave).
interface tcu_operand_loader_if #(
  parameter int DW = 32
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          res_valid;
  logic          res_ready;

  modport master (output in_valid, in_data, res_ready, input in_ready, res_valid);
  modport slave  (input in_valid, in_data, res_ready, output in_ready, res_valid);
endinterface

// File: rtl/tcu_hold_timer.sv
// Loadable down-counter that parks at zero; done flags the zero count.
module tcu_hold_timer #(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          dec,
  output logic          done
);
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                    cnt_q <= '0;
    else if (load)               cnt_q <= load_val;
    else if (dec && cnt_q != '0) cnt_q <= cnt_q - 1'b1;
  end

  assign done = (cnt_q == '0);
endmodule

// File: rtl/tcu_operand_loader.sv
// Assembles a 48-word FP32 stream into A/B/C operand rows, freezes them for
// the core latency, then presents a result strobe until acknowledged.
module tcu_operand_loader
  import tcu_operand_loader_pkg::*;
#(
  parameter int LATENCY = 12
) (
  input  logic             clk,
  input  logic             rst,
  tcu_operand_loader_if.slave bus,
  output logic [ROW_W-1:0] A_0X,
  output logic [ROW_W-1:0] A_1X,
  output logic [ROW_W-1:0] A_2X,
  output logic [ROW_W-1:0] A_3X,
  output logic [ROW_W-1:0] B_0X,
  output logic [ROW_W-1:0] B_1X,
  output logic [ROW_W-1:0] B_2X,
  output logic [ROW_W-1:0] B_3X,
  output logic [ROW_W-1:0] C_0X,
  output logic [ROW_W-1:0] C_1X,
  output logic [ROW_W-1:0] C_2X,
  output logic [ROW_W-1:0] C_3X,
  output logic             busy,
  output logic [15:0]      tile_count
);
  localparam logic [5:0] LAST_K    = 6'(NUM_WORDS - 1);
  localparam logic [7:0] HOLD_INIT = 8'(LATENCY - 1);

  state_e         state;
  logic [5:0]     k;
  logic [15:0]    tile_cnt_q;
  logic [DW-1:0]  mem [NUM_WORDS];
  logic [ROW_W-1:0] rows [12];
  logic           accept;
  logic           hold_done;

  assign accept = (state == LOAD) && bus.in_valid;

  tcu_hold_timer #(.CW(8)) u_hold_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (accept && (k == LAST_K)),
    .load_val (HOLD_INIT),
    .dec      (state == HOLD),
    .done     (hold_done)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= LOAD;
      k          <= '0;
      tile_cnt_q <= '0;
    end else begin
      case (state)
        LOAD: if (bus.in_valid) begin
          if (k == LAST_K) begin
            k     <= '0;
            state <= HOLD;
          end else begin
            k <= k + 1'b1;
          end
        end
        HOLD: if (hold_done) state <= RESULT;
        RESULT: if (bus.res_ready) begin
          state      <= LOAD;
          tile_cnt_q <= tile_cnt_q + 1'b1;
        end
        default: state <= LOAD;
      endcase
    end
  end

  // Slots are only overwritten, never cleared between tiles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_WORDS; i++) mem[i] <= '0;
    end else if (accept) begin
      mem[k] <= bus.in_data;
    end
  end

  for (genvar s = 0; s < 3; s++) begin : g_seg
    localparam int BASE = (s == 0) ? A_BASE : (s == 1) ? B_BASE : C_BASE;
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign rows[s*4+r] = {mem[BASE+4*r+3], mem[BASE+4*r+2], mem[BASE+4*r+1], mem[BASE+4*r]};
    end
  end

  assign {A_0X, A_1X, A_2X, A_3X} = {rows[0], rows[1], rows[2],  rows[3]};
  assign {B_0X, B_1X, B_2X, B_3X} = {rows[4], rows[5], rows[6],  rows[7]};
  assign {C_0X, C_1X, C_2X, C_3X} = {rows[8], rows[9], rows[10], rows[11]};

  assign bus.in_ready  = (state == LOAD);
  assign bus.res_valid = (state == RESULT);
  assign busy          = (state == HOLD) || (state == RESULT);
  assign tile_count    = tile_cnt_q;
endmodule

// File: tb/tb_tcu_operand_loader.sv
// Scoreboard bench for tcu_operand_loader: expected tiles are queued as words
// are issued and checked by a monitor when res_valid rises.
module tb_tcu_operand_loader;
  import tcu_operand_loader_pkg::*;

  localparam int LAT = 12;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  tcu_operand_loader_if #(.DW(DW)) bus ();
  logic [ROW_W-1:0] rows [12];
  logic             busy;
  logic [15:0]      tile_count;

  tcu_operand_loader #(.LATENCY(LAT)) dut (
    .clk (clk), .rst (rst), .bus (bus.slave),
    .A_0X (rows[0]), .A_1X (rows[1]), .A_2X (rows[2]),  .A_3X (rows[3]),
    .B_0X (rows[4]), .B_1X (rows[5]), .B_2X (rows[6]),  .B_3X (rows[7]),
    .C_0X (rows[8]), .C_1X (rows[9]), .C_2X (rows[10]), .C_3X (rows[11]),
    .busy (busy), .tile_count (tile_count)
  );

  typedef struct packed {
    logic [11:0][ROW_W-1:0] r;
    logic [15:0]            tc;
  } exp_t;

  exp_t          q[$];
  int            total = 0;
  int            bad   = 0;
  logic [DW-1:0] model [NUM_WORDS];
  int            k_m = 0;
  logic [15:0]   exp_tiles = '0;
  logic          push_en = 1'b1;
  int            acc = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [11:0][ROW_W-1:0] model_rows();
    logic [11:0][ROW_W-1:0] r;
    for (int g = 0; g < 12; g++)
      for (int c = 0; c < 4; c++) r[g][c*DW +: DW] = model[4*g+c];
    return r;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < NUM_WORDS; i++) model[i] = '0;
    k_m = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Holds in_valid until the word is taken; in_ready is stable between edges.
  task automatic send_word(input logic [DW-1:0] d);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    while (!bus.in_ready && n < 500) begin tick(); n++; end
    if (n >= 500) begin
      total++; bad++;
      $display("FAIL send_timeout: got in_ready=0 want 1 within 500 cycles");
    end
    tick();
    bus.in_valid = 1'b0;
    model[k_m] = d;
    k_m++;
    if (k_m == NUM_WORDS) begin
      k_m = 0;
      if (push_en) q.push_back('{r: model_rows(), tc: exp_tiles});
    end
  endtask

  task automatic wait_res();
    int n = 0;
    while (!bus.res_valid && n < 400) begin tick(); n++; end
    check("res_valid_wait", 128'(bus.res_valid), 128'd1);
  endtask

  // Monitor: counts handshakes and scores each tile on res_valid rising.
  initial begin : monitor
    logic prev_rv;
    exp_t e;
    prev_rv = 1'b0;
    forever begin
      @(negedge clk);
      if (rst && bus.in_valid && bus.in_ready) acc = acc + 1;
      if (bus.res_valid && !prev_rv) begin
        if (q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_result: got res_valid=1 want no pending tile");
        end else begin
          e = q.pop_front();
          for (int g = 0; g < 12; g++) check($sformatf("row%0d", g), 128'(rows[g]), 128'(e.r[g]));
          check("tile_count_at_result", 128'(tile_count), 128'(e.tc));
        end
      end
      prev_rv = bus.res_valid;
    end
  end

  initial begin
    int acc0;
    logic [11:0][ROW_W-1:0] er;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.res_ready = 1'b1;
    clear_model();

    #2;
    for (int g = 0; g < 12; g++) check($sformatf("reset_row%0d", g), 128'(rows[g]), 128'd0);
    check("reset_in_ready",   128'(bus.in_ready),  128'd1);
    check("reset_res_valid",  128'(bus.res_valid), 128'd0);
    check("reset_busy",       128'(busy),          128'd0);
    check("reset_tile_count", 128'(tile_count),    128'd0);
    tick();
    rst = 1'b1;

    // Reset five cycles into HOLD discards the tile.
    push_en = 1'b0;
    for (int i = 0; i < NUM_WORDS; i++) begin
      send_word(32'h200 + 32'(i));
      if (i == 0) check("word_next_cycle", 128'(rows[0][DW-1:0]), 128'h200);
    end
    check("hold_busy",     128'(busy),         128'd1);
    check("hold_in_ready", 128'(bus.in_ready), 128'd0);
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    for (int g = 0; g < 12; g++) check($sformatf("midhold_row%0d", g), 128'(rows[g]), 128'd0);
    check("midhold_in_ready",   128'(bus.in_ready), 128'd1);
    check("midhold_busy",       128'(busy),         128'd0);
    check("midhold_tile_count", 128'(tile_count),   128'd0);
    clear_model();
    push_en = 1'b1;
    tick();
    rst = 1'b1;

    // Packing and latency.
    for (int i = 0; i < NUM_WORDS; i++) send_word(32'h100 + 32'(i));
    for (int t = 0; t < LAT; t++) begin
      check($sformatf("lat_res_valid_T0+%0d", t), 128'(bus.res_valid), 128'd0);
      check($sformatf("lat_in_ready_T0+%0d", t),  128'(bus.in_ready),  128'd0);
      tick();
    end
    check("lat_res_valid_T0+12", 128'(bus.res_valid), 128'd1);
    check("lat_in_ready_T0+12",  128'(bus.in_ready),  128'd0);
    check("pack_A_0X", 128'(rows[0]),  128'h00000103_00000102_00000101_00000100);
    check("pack_B_0X", 128'(rows[4]),  128'h00000113_00000112_00000111_00000110);
    check("pack_C_3X", 128'(rows[11]), 128'h0000012F_0000012E_0000012D_0000012C);
    tick();
    check("pack_in_ready_after", 128'(bus.in_ready), 128'd1);
    check("pack_tile_count",     128'(tile_count),   128'd1);
    exp_tiles = 16'd1;

    // Backpressure on both sides.
    bus.res_ready = 1'b0;
    acc0 = acc;
    for (int i = 0; i < NUM_WORDS; i++) begin
      if (i % 3 == 2) tick();
      send_word(32'h500 + 32'(i));
    end
    wait_res();
    check("bp_words_accepted", 128'(acc - acc0), 128'd48);
    er = model_rows();
    bus.in_valid = 1'b1;
    bus.in_data  = 32'hDEADBEEF;
    for (int t = 0; t < 20; t++) begin
      check("bp_res_valid_held", 128'(bus.res_valid), 128'd1);
      check("bp_A_0X_frozen",    128'(rows[0]),       128'(er[0]));
      check("bp_C_3X_frozen",    128'(rows[11]),      128'(er[11]));
      tick();
    end
    check("bp_no_accept", 128'(acc - acc0), 128'd48);
    bus.in_valid  = 1'b0;
    bus.res_ready = 1'b1;
    tick();
    check("bp_tile_count", 128'(tile_count),   128'd2);
    check("bp_in_ready",   128'(bus.in_ready), 128'd1);
    exp_tiles = 16'd2;

    // Identity A, B = 2.0, C = 1.0.
    for (int i = 0; i < 16; i++) send_word(((i / 4) == (i % 4)) ? 32'h3F800000 : 32'h0);
    for (int i = 0; i < 16; i++) send_word(32'h40000000);
    for (int i = 0; i < 16; i++) send_word(32'h3F800000);
    wait_res();
    check("id_A_1X", 128'(rows[1]), 128'h00000000_00000000_3F800000_00000000);
    check("id_B_2X", 128'(rows[6]), {4{32'h40000000}});
    check("id_C_0X", 128'(rows[8]), {4{32'h3F800000}});
    tick();
    check("id_tile_count", 128'(tile_count), 128'd3);

    // Counter wrap.
    @(negedge clk);
    force dut.tile_cnt_q = 16'hFFFF;
    tick();
    release dut.tile_cnt_q;
    check("wrap_preset", 128'(tile_count), 128'hFFFF);
    exp_tiles = 16'hFFFF;
    for (int i = 0; i < NUM_WORDS; i++) send_word(32'h300 + 32'(i));
    wait_res();
    tick();
    check("wrap_tile_count", 128'(tile_count), 128'd0);

    check("queue_drained", 128'(q.size()), 128'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got still running want finished");
    $fatal(1);
  end
endmodule
